// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// funct fields, ALU control codes, decoder selectors and fault codes.
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_IEXEC   = 4'd9,
      S_IWB     = 4'd10,
      S_JUMP    = 4'd11,
      S_JAL     = 4'd12,
      S_FAULT   = 4'd13
   } mc_state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_LBU   = 6'b100100;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_SRLV  = 6'b000110;
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_XOR   = 6'b100110;
   localparam logic [5:0] FN_SLT   = 6'b101010;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_XOR  = 4'b0011;
   localparam logic [3:0] ALU_SRLV = 4'b0100;
   localparam logic [3:0] ALU_SUB  = 4'b1010;
   localparam logic [3:0] ALU_SLT  = 4'b1011;

   localparam logic [2:0] AOP_ADD   = 3'd0;
   localparam logic [2:0] AOP_SUB   = 3'd1;
   localparam logic [2:0] AOP_FUNCT = 3'd2;
   localparam logic [2:0] AOP_OR    = 3'd3;
   localparam logic [2:0] AOP_XOR   = 3'd4;

   localparam logic [1:0] FAULT_NONE    = 2'b00;
   localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
   localparam logic [1:0] FAULT_TMO     = 2'b10;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps the FSM's aluop selector (and funct for R-type) to alucontrol.
// illegal_funct depends only on funct so DECODE can use it while aluop selects add.
module mc_aludec
   import mc_pkg::*;
(
   input  logic [2:0] aluop,
   input  logic [5:0] funct,
   output logic [3:0] alucontrol,
   output logic       illegal_funct
);

   logic [3:0] fn_ctrl;

   always_comb begin
      fn_ctrl       = ALU_ADD;
      illegal_funct = 1'b0;
      case (funct)
         FN_ADD:  fn_ctrl = ALU_ADD;
         FN_SUB:  fn_ctrl = ALU_SUB;
         FN_AND:  fn_ctrl = ALU_AND;
         FN_OR:   fn_ctrl = ALU_OR;
         FN_XOR:  fn_ctrl = ALU_XOR;
         FN_SLT:  fn_ctrl = ALU_SLT;
         FN_SRLV: fn_ctrl = ALU_SRLV;
         default: illegal_funct = 1'b1;
      endcase
   end

   always_comb begin
      case (aluop)
         AOP_SUB:   alucontrol = ALU_SUB;
         AOP_FUNCT: alucontrol = fn_ctrl;
         AOP_OR:    alucontrol = ALU_OR;
         AOP_XOR:   alucontrol = ALU_XOR;
         default:   alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: main FSM with memory wait/timeout, sticky fault,
// retired-instruction counter and combinational control decode from the state.
module mc_controller
   import mc_pkg::*;
#(
   parameter int unsigned RETIRE_W = 32,
   parameter int unsigned TMO_W    = 8,
   parameter int unsigned TMO_MAX  = 200
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [5:0]          op,
   input  logic [5:0]          funct,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                mem_req,
   output logic                pcen,
   output logic                memwrite,
   output logic                irwrite,
   output logic                regwrite,
   output logic                alusrca,
   output logic                iord,
   output logic [1:0]          regdst,
   output logic [1:0]          memtoreg,
   output logic [2:0]          alusrcb,
   output logic [1:0]          pcsrc,
   output logic [3:0]          alucontrol,
   output logic                lbu,
   output logic [1:0]          fault,
   output logic [RETIRE_W-1:0] retired,
   output mc_state_t           dbg_state
);

   localparam logic [TMO_W-1:0]    TMO_LAST = TMO_W'(TMO_MAX - 1);
   localparam logic [TMO_W-1:0]    WAIT_ONE = {{(TMO_W-1){1'b0}}, 1'b1};
   localparam logic [RETIRE_W-1:0] RET_ONE  = {{(RETIRE_W-1){1'b0}}, 1'b1};

   mc_state_t        state;
   logic [TMO_W-1:0] wait_cnt;
   logic [2:0]       aluop;
   logic             pcwrite, branch, bne, illegal_funct;
   logic             rdy, waiting, retire_evt;

   // Memory handshake: mem_req is held high for the whole access; the access
   // completes in the cycle mem_ready is high. A sampled reset cancels it.
   assign rdy     = mem_ready & reset;
   assign waiting = mem_req & ~mem_ready;

   mc_aludec u_aludec (
      .aluop         (aluop),
      .funct         (funct),
      .alucontrol    (alucontrol),
      .illegal_funct (illegal_funct)
   );

   always_comb begin
      mem_req  = 1'b0;
      pcwrite  = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      alusrca  = 1'b0;
      iord     = 1'b0;
      regdst   = 2'b00;
      memtoreg = 2'b00;
      alusrcb  = 3'b000;
      pcsrc    = 2'b00;
      aluop    = AOP_ADD;
      lbu      = 1'b0;
      branch   = 1'b0;
      bne      = 1'b0;
      case (state)
         S_FETCH: begin
            mem_req = 1'b1;
            alusrcb = 3'b001;
            pcwrite = rdy;
            irwrite = rdy;
         end
         S_DECODE:  alusrcb = 3'b011;
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 3'b010;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
         end
         S_MEMWR: begin
            mem_req  = 1'b1;
            iord     = 1'b1;
            memwrite = 1'b1;
         end
         S_MEMWB: begin
            regwrite = 1'b1;
            memtoreg = 2'b01;
            lbu      = (op == OP_LBU);
         end
         S_EXECUTE: begin
            alusrca = 1'b1;
            aluop   = AOP_FUNCT;
         end
         S_ALUWB: begin
            regwrite = 1'b1;
            regdst   = 2'b01;
         end
         S_BRANCH: begin
            alusrca = 1'b1;
            aluop   = AOP_SUB;
            pcsrc   = 2'b01;
            branch  = (op == OP_BEQ);
            bne     = (op == OP_BNE);
         end
         S_IEXEC: begin
            alusrca = 1'b1;
            case (op)
               OP_ORI: begin
                  alusrcb = 3'b100;
                  aluop   = AOP_OR;
               end
               OP_XORI: begin
                  alusrcb = 3'b100;
                  aluop   = AOP_XOR;
               end
               default: alusrcb = 3'b010;
            endcase
         end
         S_IWB:     regwrite = 1'b1;
         S_JUMP: begin
            pcwrite = 1'b1;
            pcsrc   = 2'b10;
         end
         S_JAL: begin
            pcwrite  = 1'b1;
            pcsrc    = 2'b10;
            regwrite = 1'b1;
            regdst   = 2'b10;
            memtoreg = 2'b10;
         end
         default: ;
      endcase
   end

   assign pcen      = pcwrite | (branch & zero) | (bne & ~zero);
   assign dbg_state = state;

   always_comb begin
      case (state)
         S_MEMWB, S_ALUWB, S_BRANCH, S_IWB, S_JUMP, S_JAL: retire_evt = 1'b1;
         S_MEMWR: retire_evt = mem_ready;
         default: retire_evt = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= S_FETCH;
         wait_cnt <= '0;
         fault    <= FAULT_NONE;
         retired  <= '0;
      end else begin
         // A waiting cycle never changes state, so clearing on any non-waiting cycle
         // is the same as clearing on every state change.
         wait_cnt <= waiting ? wait_cnt + WAIT_ONE : '0;
         if (retire_evt)
            retired <= retired + RET_ONE;
         if (waiting && wait_cnt == TMO_LAST) begin
            state    <= S_FAULT;
            fault    <= FAULT_TMO;
            wait_cnt <= '0;
         end else begin
            case (state)
               S_FETCH:  if (mem_ready) state <= S_DECODE;
               S_DECODE: begin
                  case (op)
                     OP_LW, OP_SW, OP_LBU:    state <= S_MEMADR;
                     OP_BEQ, OP_BNE:          state <= S_BRANCH;
                     OP_ADDI, OP_ORI, OP_XORI: state <= S_IEXEC;
                     OP_J:                    state <= S_JUMP;
                     OP_JAL:                  state <= S_JAL;
                     OP_RTYPE: begin
                        if (illegal_funct) begin
                           state <= S_FAULT;
                           fault <= FAULT_ILLEGAL;
                        end else begin
                           state <= S_EXECUTE;
                        end
                     end
                     default: begin
                        state <= S_FAULT;
                        fault <= FAULT_ILLEGAL;
                     end
                  endcase
               end
               S_MEMADR:  state <= (op == OP_SW) ? S_MEMWR : S_MEMRD;
               S_MEMRD:   if (mem_ready) state <= S_MEMWB;
               S_MEMWR:   if (mem_ready) state <= S_FETCH;
               S_EXECUTE: state <= S_ALUWB;
               S_IEXEC:   state <= S_IWB;
               S_MEMWB, S_ALUWB, S_BRANCH, S_IWB, S_JUMP, S_JAL: state <= S_FETCH;
               default:   state <= state;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: one task per scenario, hand-computed expectations.
module tb_mc_controller;
   import mc_pkg::*;

   logic        clk, reset, zero, mem_ready;
   logic [5:0]  op, funct;
   logic        mem_req, pcen, memwrite, irwrite, regwrite, alusrca, iord, lbu;
   logic [1:0]  regdst, memtoreg, pcsrc, fault;
   logic [2:0]  alusrcb;
   logic [3:0]  alucontrol;
   logic [31:0] retired;
   mc_state_t   dbg_state;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_ret = '0;

   mc_controller #(.RETIRE_W(32), .TMO_W(8), .TMO_MAX(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct      (funct),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .pcen       (pcen),
      .memwrite   (memwrite),
      .irwrite    (irwrite),
      .regwrite   (regwrite),
      .alusrca    (alusrca),
      .iord       (iord),
      .regdst     (regdst),
      .memtoreg   (memtoreg),
      .alusrcb    (alusrcb),
      .pcsrc      (pcsrc),
      .alucontrol (alucontrol),
      .lbu        (lbu),
      .fault      (fault),
      .retired    (retired),
      .dbg_state  (dbg_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic rdy);
      reset     = 1'b0;
      mem_ready = rdy;
      tick;
      tick;
      reset = 1'b1;
   endtask

   task automatic test_reset;
      reset = 1'b0; mem_ready = 1'b1; op = OP_RTYPE; funct = FN_SUB; zero = 1'b0;
      tick;
      tick;
      #1;
      checks++; if (dbg_state !== S_FETCH) begin errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, S_FETCH); end
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL reset_mem_req: got %b want 1", mem_req); end
      checks++; if (retired !== 32'd0) begin errors++; $display("FAIL reset_retired: got %0d want 0", retired); end
      checks++; if (fault !== FAULT_NONE) begin errors++; $display("FAIL reset_fault: got %b want 00", fault); end
      checks++; if ({pcen, irwrite} !== 2'b00) begin errors++; $display("FAIL reset_blocks_write: got %b want 00", {pcen, irwrite}); end
      reset = 1'b1;
      #1;
      checks++; if ({pcen, irwrite} !== 2'b11) begin errors++; $display("FAIL release_fetch: got %b want 11", {pcen, irwrite}); end
      tick;
      checks++; if (dbg_state !== S_DECODE || {pcen, irwrite} !== 2'b00) begin
         errors++; $display("FAIL release_pulse: state %0d pcen/ir %b want %0d 00", dbg_state, {pcen, irwrite}, S_DECODE);
      end
      exp_ret = '0;
   endtask

   task automatic test_rtype;
      tick;
      checks++; if (dbg_state !== S_EXECUTE || alucontrol !== ALU_SUB || alusrca !== 1'b1 || alusrcb !== 3'b000) begin
         errors++; $display("FAIL rtype_exec: state %0d ctl %b srca %b srcb %b want %0d 1010 1 000", dbg_state, alucontrol, alusrca, alusrcb, S_EXECUTE);
      end
      tick;
      checks++; if (regwrite !== 1'b1 || regdst !== 2'b01 || memtoreg !== 2'b00) begin
         errors++; $display("FAIL rtype_wb: rw %b dst %b m2r %b want 1 01 00", regwrite, regdst, memtoreg);
      end
      tick;
      exp_ret++;
      checks++; if (dbg_state !== S_FETCH || retired !== exp_ret) begin
         errors++; $display("FAIL rtype_retire: state %0d ret %0d want %0d %0d", dbg_state, retired, S_FETCH, exp_ret);
      end
   endtask

   task automatic test_lw_wait;
      int cyc, pulses;
      bit done;
      op = OP_LW; cyc = 0; pulses = 0; done = 1'b0;
      for (int c = 1; c <= 20 && !done; c++) begin
         mem_ready = (c < 4 || c > 6);
         #1;
         if (regwrite === 1'b1) begin
            pulses++;
            checks++; if (memtoreg !== 2'b01) begin errors++; $display("FAIL lw_memtoreg: got %b want 01", memtoreg); end
         end
         if (c == 5) begin
            checks++; if (dbg_state !== S_MEMRD || mem_req !== 1'b1 || iord !== 1'b1) begin
               errors++; $display("FAIL lw_memrd: state %0d req %b iord %b want %0d 1 1", dbg_state, mem_req, iord, S_MEMRD);
            end
         end
         tick;
         if (dbg_state == S_FETCH) begin
            done = 1'b1;
            cyc  = c;
         end
      end
      mem_ready = 1'b1;
      exp_ret++;
      checks++; if (cyc !== 8) begin errors++; $display("FAIL lw_latency: got %0d want 8", cyc); end
      checks++; if (pulses !== 1) begin errors++; $display("FAIL lw_regwrite_pulses: got %0d want 1", pulses); end
      checks++; if (retired !== exp_ret) begin errors++; $display("FAIL lw_retire: got %0d want %0d", retired, exp_ret); end
   endtask

   task automatic test_sw_lbu;
      op = OP_SW; mem_ready = 1'b1;
      tick; tick; tick;
      checks++; if (dbg_state !== S_MEMWR || memwrite !== 1'b1 || mem_req !== 1'b1 || iord !== 1'b1) begin
         errors++; $display("FAIL sw_memwr: state %0d mw %b req %b iord %b want %0d 1 1 1", dbg_state, memwrite, mem_req, iord, S_MEMWR);
      end
      tick;
      exp_ret++;
      checks++; if (dbg_state !== S_FETCH || retired !== exp_ret) begin
         errors++; $display("FAIL sw_retire: state %0d ret %0d want %0d %0d", dbg_state, retired, S_FETCH, exp_ret);
      end
      op = OP_LBU;
      tick; tick; tick; tick;
      checks++; if (dbg_state !== S_MEMWB || lbu !== 1'b1 || regwrite !== 1'b1) begin
         errors++; $display("FAIL lbu_wb: state %0d lbu %b rw %b want %0d 1 1", dbg_state, lbu, regwrite, S_MEMWB);
      end
      tick;
      exp_ret++;
   endtask

   task automatic test_branch;
      for (int z = 0; z < 2; z++) begin
         op = OP_BNE; zero = (z == 1);
         tick; tick;
         checks++; if (dbg_state !== S_BRANCH || pcen !== (z == 0) || pcsrc !== 2'b01 || alucontrol !== ALU_SUB) begin
            errors++; $display("FAIL bne_zero%0d: state %0d pcen %b pcsrc %b ctl %b want %0d %b 01 1010", z, dbg_state, pcen, pcsrc, alucontrol, S_BRANCH, (z == 0));
         end
         tick;
         exp_ret++;
         checks++; if (dbg_state !== S_FETCH || retired !== exp_ret) begin
            errors++; $display("FAIL bne_return%0d: state %0d ret %0d want %0d %0d", z, dbg_state, retired, S_FETCH, exp_ret);
         end
      end
      op = OP_BEQ; zero = 1'b1;
      tick; tick;
      checks++; if (pcen !== 1'b1) begin errors++; $display("FAIL beq_taken: got %b want 1", pcen); end
      tick;
      exp_ret++;
      zero = 1'b0;
   endtask

   task automatic test_jumps;
      op = OP_JAL;
      tick; tick;
      checks++; if (dbg_state !== S_JAL || regwrite !== 1'b1 || regdst !== 2'b10 || memtoreg !== 2'b10 || pcsrc !== 2'b10 || pcen !== 1'b1) begin
         errors++; $display("FAIL jal: state %0d rw %b dst %b m2r %b pcsrc %b pcen %b want %0d 1 10 10 10 1",
                            dbg_state, regwrite, regdst, memtoreg, pcsrc, pcen, S_JAL);
      end
      tick;
      exp_ret++;
      op = OP_J;
      tick; tick;
      checks++; if (dbg_state !== S_JUMP || pcen !== 1'b1 || pcsrc !== 2'b10 || regwrite !== 1'b0) begin
         errors++; $display("FAIL jump: state %0d pcen %b pcsrc %b rw %b want %0d 1 10 0", dbg_state, pcen, pcsrc, regwrite, S_JUMP);
      end
      tick;
      exp_ret++;
      checks++; if (retired !== exp_ret) begin errors++; $display("FAIL jump_retire: got %0d want %0d", retired, exp_ret); end
   endtask

   task automatic test_itype;
      logic [5:0] ops  [3];
      logic [2:0] srcb [3];
      logic [3:0] ctl  [3];
      ops  = '{OP_ADDI, OP_ORI, OP_XORI};
      srcb = '{3'b010, 3'b100, 3'b100};
      ctl  = '{ALU_ADD, ALU_OR, ALU_XOR};
      for (int i = 0; i < 3; i++) begin
         op = ops[i];
         tick; tick;
         checks++; if (dbg_state !== S_IEXEC || alusrcb !== srcb[i] || alucontrol !== ctl[i] || alusrca !== 1'b1) begin
            errors++; $display("FAIL iexec_%0d: state %0d srcb %b ctl %b srca %b want %0d %b %b 1", i, dbg_state, alusrcb, alucontrol, alusrca, S_IEXEC, srcb[i], ctl[i]);
         end
         tick;
         checks++; if (regwrite !== 1'b1 || regdst !== 2'b00 || memtoreg !== 2'b00) begin
            errors++; $display("FAIL iwb_%0d: rw %b dst %b m2r %b want 1 00 00", i, regwrite, regdst, memtoreg);
         end
         tick;
         exp_ret++;
      end
      checks++; if (retired !== exp_ret) begin errors++; $display("FAIL itype_retire: got %0d want %0d", retired, exp_ret); end
   endtask

   task automatic test_illegal;
      op = OP_RTYPE; funct = 6'b000111;
      tick; tick;
      checks++; if (dbg_state !== S_FAULT || fault !== FAULT_ILLEGAL || mem_req !== 1'b0 || pcen !== 1'b0) begin
         errors++; $display("FAIL illegal_funct: state %0d fault %b req %b pcen %b want %0d 01 0 0", dbg_state, fault, mem_req, pcen, S_FAULT);
      end
      for (int i = 0; i < 5; i++) tick;
      checks++; if (dbg_state !== S_FAULT || fault !== FAULT_ILLEGAL || retired !== exp_ret || regwrite !== 1'b0) begin
         errors++; $display("FAIL fault_sticky: state %0d fault %b ret %0d rw %b want %0d 01 %0d 0", dbg_state, fault, retired, regwrite, S_FAULT, exp_ret);
      end
      funct = FN_ADD;
   endtask

   task automatic test_timeout;
      do_reset(1'b0);
      checks++; if (retired !== 32'd0 || fault !== FAULT_NONE) begin
         errors++; $display("FAIL rereset: ret %0d fault %b want 0 00", retired, fault);
      end
      tick; tick; tick;
      checks++; if (dbg_state !== S_FETCH) begin errors++; $display("FAIL tmo_before: got %0d want %0d", dbg_state, S_FETCH); end
      tick;
      checks++; if (dbg_state !== S_FAULT || fault !== FAULT_TMO || mem_req !== 1'b0) begin
         errors++; $display("FAIL tmo_fault: state %0d fault %b req %b want %0d 10 0", dbg_state, fault, mem_req, S_FAULT);
      end
      do_reset(1'b0);
      tick; tick; tick;
      mem_ready = 1'b1;
      #1;
      checks++; if (irwrite !== 1'b1) begin errors++; $display("FAIL tmo_ready_ir: got %b want 1", irwrite); end
      tick;
      checks++; if (dbg_state !== S_DECODE || fault !== FAULT_NONE) begin
         errors++; $display("FAIL tmo_ready_wins: state %0d fault %b want %0d 00", dbg_state, fault, S_DECODE);
      end
   endtask

   initial begin
      test_reset;
      test_rtype;
      test_lw_wait;
      test_sw_lbu;
      test_branch;
      test_jumps;
      test_itype;
      test_illegal;
      test_timeout;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

endmodule
